// File: rtl/ps2_key_rx_if.sv
// Key-event bundle produced by the PS/2 receiver: assembled key, break flag,
// strobes, modifier state and a debug view of the frame FSM state.
interface ps2_key_rx_if;
  logic [15:0] o_key;
  logic        o_brk;
  logic        o_valid;
  logic [15:0] o_shft;
  logic        o_err;
  logic [1:0]  dbg_state;

  modport master (output o_key, o_brk, o_valid, o_shft, o_err, dbg_state);
  modport slave  (input  o_key, o_brk, o_valid, o_shft, o_err, dbg_state);
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 device-to-host receiver: sync + glitch filter, 11-bit frame FSM, E0/F0 merge.
// Optional PS2_TYPEMATIC_FILT_EN suppresses repeated makes of the last key.
module ps2_key_rx #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TIMEOUT_US  = 1000,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ps2_clk,
  input  logic            i_ps2_dat,
  ps2_key_rx_if.master    key_if
);
  localparam int TMO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW      = $clog2(TMO_CYC + 1);
  localparam int FW      = $clog2(FILT_LEN + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic                   filt_clk_q, filt_clk_d;
  logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   par_ok_q, par_ok_d;
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic                   ext_q, ext_d, brk_q, brk_d;
  logic [15:0]            key_q, key_d;
  logic                   brk_out_q, brk_out_d, valid_q, valid_d, err_q, err_d;
  logic [5:0]             mods_q, mods_d;
  logic                   fall, dat_s, tmo_exp, frame_good, frame_bad, emit;
  logic [15:0]            ev_key;

  // Pin synchronisers and clock filter: the filtered level flips only after
  // FILT_LEN consecutive samples disagree with it.
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], i_ps2_dat};
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_sync_q[SYNC_STAGES-1] != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILT_LEN - 1)) filt_clk_d = ~filt_clk_q;
      else                                 filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign fall  = filt_clk_q & ~filt_clk_d;
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // A fall in the expiry cycle wins, so expiry requires no fall.
  always_comb begin
    tmo_exp   = (state_q != ST_IDLE) && !fall && (tmo_cnt_q == TW'(TMO_CYC - 1));
    tmo_cnt_d = (fall || state_q == ST_IDLE) ? '0 : tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fall && !dat_s)             state_d = ST_DATA;
      ST_DATA:   if (fall && bit_cnt_q == 3'd7)  state_d = ST_PARITY;
      ST_PARITY: if (fall)                       state_d = ST_STOP;
      ST_STOP:   if (fall)                       state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
    if (tmo_exp) state_d = ST_IDLE;
  end

  // Parity/stop are judged together at the stop bit so a bad frame is
  // consumed completely before returning to IDLE.
  always_comb begin
    frame_good = fall && (state_q == ST_STOP) && dat_s && par_ok_q;
    frame_bad  = fall && (state_q == ST_STOP) && !(dat_s && par_ok_q);
  end

  always_comb begin
    bit_cnt_d = (state_q == ST_IDLE) ? 3'd0 : bit_cnt_q;
    shreg_d   = shreg_q;
    par_ok_d  = par_ok_q;
    if (fall) begin
      case (state_q)
        ST_DATA: begin
          shreg_d   = {dat_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        ST_PARITY: par_ok_d = ^{shreg_q, dat_s};
        default: ;
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILT_EN
  logic [15:0] last_make_q, last_make_d;
  logic        last_vld_q, last_vld_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_make_q <= '0;
      last_vld_q  <= 1'b0;
    end else begin
      last_make_q <= last_make_d;
      last_vld_q  <= last_vld_d;
    end
  end
`endif

  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    key_d     = key_q;
    brk_out_d = brk_out_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    mods_d    = mods_q;
    emit      = 1'b0;
    ev_key    = {ext_q ? 8'hE0 : 8'h00, shreg_q};
`ifdef PS2_TYPEMATIC_FILT_EN
    last_make_d = last_make_q;
    last_vld_d  = last_vld_q;
`endif
    if (frame_bad || tmo_exp) begin
      err_d = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (frame_good) begin
      if (shreg_q == 8'hE0)      ext_d = 1'b1;
      else if (shreg_q == 8'hF0) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        emit  = 1'b1;
`ifdef PS2_TYPEMATIC_FILT_EN
        if (!brk_q && last_vld_q && ev_key == last_make_q) emit = 1'b0;
        else if (!brk_q) begin
          last_make_d = ev_key;
          last_vld_d  = 1'b1;
        end else if (ev_key == last_make_q) last_vld_d = 1'b0;
`endif
      end
    end
    if (emit) begin
      valid_d   = 1'b1;
      key_d     = ev_key;
      brk_out_d = brk_q;
      case (ev_key)
        16'h0012: mods_d[0] = ~brk_q;
        16'h0059: mods_d[1] = ~brk_q;
        16'h0014: mods_d[2] = ~brk_q;
        16'hE014: mods_d[3] = ~brk_q;
        16'h0011: mods_d[4] = ~brk_q;
        16'hE011: mods_d[5] = ~brk_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_ok_q   <= 1'b0;
      tmo_cnt_q  <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_q      <= '0;
      brk_out_q  <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      mods_q     <= '0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_ok_q   <= par_ok_d;
      tmo_cnt_q  <= tmo_cnt_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      key_q      <= key_d;
      brk_out_q  <= brk_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      mods_q     <= mods_d;
    end
  end

  assign key_if.o_key     = key_q;
  assign key_if.o_brk     = brk_out_q;
  assign key_if.o_valid   = valid_q;
  assign key_if.o_err     = err_q;
  assign key_if.o_shft    = {10'b0, mods_q};
  assign key_if.dbg_state = state_q;
endmodule

// File: tb/tb_ps2_key_rx.sv
// Randomised + directed bench for ps2_key_rx against a frame/event-level model.
module tb_ps2_key_rx;
  localparam int HP = 8;  // PS/2 half period in system clocks

  logic clk, rst_n, ps2_clk, ps2_dat;
  ps2_key_rx_if key_if ();

  ps2_key_rx #(.CLK_HZ(1_000_000), .TIMEOUT_US(200), .SYNC_STAGES(2), .FILT_LEN(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat), .key_if(key_if));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;
  int cnt_valid = 0, cnt_err = 0;
  logic [15:0] seen_key, seen_shft;
  logic        seen_brk;

  // expected events packed as {err, key[15:0], brk, shft[15:0]}
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // behavioural model
  localparam logic [15:0] MOD_KEYS [6] = '{16'h0012, 16'h0059, 16'h0014, 16'hE014, 16'h0011, 16'hE011};
  logic        m_ext, m_brk;
  logic [5:0]  m_mods;
  logic [15:0] m_last;
  logic        m_last_vld;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_mods = '0; m_last = '0; m_last_vld = 0;
    exp_q.delete();
  endtask

  task automatic model_err();
    exp_q.push_back({1'b1, 16'h0, 1'b0, 16'h0});
    m_ext = 0; m_brk = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    logic [15:0] k;
    bit keep;
    if (!good) begin model_err(); return; end
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    k = m_ext ? {8'hE0, b} : {8'h00, b};
    keep = 1;
`ifdef PS2_TYPEMATIC_FILT_EN
    if (!m_brk) begin
      if (m_last_vld && m_last == k) keep = 0;
      else begin m_last = k; m_last_vld = 1; end
    end else if (m_last_vld && m_last == k) m_last_vld = 0;
`endif
    if (keep) begin
      for (int i = 0; i < 6; i++) if (k == MOD_KEYS[i]) m_mods[i] = !m_brk;
      exp_q.push_back({1'b0, k, m_brk, 10'b0, m_mods});
    end
    m_ext = 0; m_brk = 0;
  endtask

  // compare process
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_if.o_valid && key_if.o_err) check("valid_and_err", 34'd1, 34'd0);
      if (key_if.o_valid || key_if.o_err) begin
        logic [33:0] e;
        if (key_if.o_valid) begin
          cnt_valid++;
          seen_key = key_if.o_key; seen_brk = key_if.o_brk; seen_shft = key_if.o_shft;
        end
        if (key_if.o_err) cnt_err++;
        if (exp_q.size() == 0) check("unexpected_event", {key_if.o_err, key_if.o_key, key_if.o_brk, key_if.o_shft}, 34'h3FFFFFFFF);
        else begin
          e = exp_q.pop_front();
          if (e[33]) check("err_event", {33'd0, key_if.o_err}, 34'd1);
          else check("key_event", {key_if.o_err, key_if.o_key, key_if.o_brk, key_if.o_shft}, e);
        end
      end
    end
  end

  // drivers
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = f[i];
      cyc(HP);
      ps2_clk = 1'b0;
      cyc(HP);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    model_frame(b, !bad_par && !bad_stop);
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    ps2_dat = 1'b1;
    cyc(30);
  endtask

  task automatic drained(input string name);
    check(name, 34'(exp_q.size()), 34'd0);
  endtask

  int v0, e0;

  initial begin
    rst_n = 0; ps2_clk = 1; ps2_dat = 1;
    model_reset();
    cyc(5);
    check("rst_outs", {key_if.o_valid, key_if.o_err, key_if.o_key, key_if.o_brk, key_if.o_shft}, 34'd0);
    check("rst_state", 34'(key_if.dbg_state), 34'd0);
    rst_n = 1;
    cyc(10);

    // 1: single make
    v0 = cnt_valid; e0 = cnt_err;
    send_frame(8'h1C, 0, 0);
    check("t1_nvalid", 34'(cnt_valid - v0), 34'd1);
    check("t1_nerr", 34'(cnt_err - e0), 34'd0);
    check("t1_key", {seen_brk, seen_key}, {1'b0, 16'h001C});
    drained("t1_drain");

    // 2: break
    v0 = cnt_valid;
    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
    check("t2_nvalid", 34'(cnt_valid - v0), 34'd1);
    check("t2_key", {seen_brk, seen_key}, {1'b1, 16'h001C});

    // 3: extended break then plain make
    v0 = cnt_valid;
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    check("t3_nvalid", 34'(cnt_valid - v0), 34'd1);
    check("t3_key", {seen_brk, seen_key}, {1'b1, 16'hE075});
    send_frame(8'h1C, 0, 0);
    check("t3_key2", {seen_brk, seen_key}, {1'b0, 16'h001C});

    // 4: modifiers
    send_frame(8'h12, 0, 0);
    check("t4_shft_make", 34'(seen_shft), 34'h0001);
    send_frame(8'hF0, 0, 0); send_frame(8'h12, 0, 0);
    check("t4_shft_brk", 34'(seen_shft), 34'h0000);
    send_frame(8'hE0, 0, 0); send_frame(8'h14, 0, 0);
    check("t4_shft_rctl", 34'(seen_shft), 34'h0008);

    // 5: parity error then good
    v0 = cnt_valid; e0 = cnt_err;
    send_frame(8'h16, 1, 0);
    check("t5_nerr", 34'(cnt_err - e0), 34'd1);
    check("t5_nvalid", 34'(cnt_valid - v0), 34'd0);
    send_frame(8'h16, 0, 0);
    check("t5_key", 34'(seen_key), 34'h0016);
    e0 = cnt_err;
    send_frame(8'h2A, 0, 1);
    check("t5_stop_err", 34'(cnt_err - e0), 34'd1);

    // 6: timeout mid-frame
    e0 = cnt_err; v0 = cnt_valid;
    model_err();
    send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 6);
    ps2_dat = 1;
    cyc(300);
    check("t6_tmo_err", 34'(cnt_err - e0), 34'd1);
    check("t6_idle", 34'(key_if.dbg_state), 34'd0);
    send_frame(8'h1C, 0, 0);
    check("t6_after", {2'b0, 16'(cnt_valid - v0), seen_key}, {2'b0, 16'd1, 16'h001C});
    drained("t6_drain");

    // reset mid-frame
    send_frame(8'h11, 0, 0);
    v0 = cnt_valid;
    send_bits({1'b1, 1'b0, 8'h33, 1'b0}, 5);
    rst_n = 0;
    model_reset();
    cyc(3);
    check("mrst_outs", {key_if.o_valid, key_if.o_err, key_if.o_key, key_if.o_brk, key_if.o_shft}, 34'd0);
    ps2_clk = 1; ps2_dat = 1;
    cyc(3);
    rst_n = 1;
    cyc(40);
    check("mrst_nostrobe", 34'(cnt_valid - v0), 34'd0);

    // 7: typematic repeats
    v0 = cnt_valid;
    send_frame(8'h1C, 0, 0); send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
    send_frame(8'h1C, 0, 0);
`ifdef PS2_TYPEMATIC_FILT_EN
    check("t7_strobes", 34'(cnt_valid - v0), 34'd3);
`else
    check("t7_strobes", 34'(cnt_valid - v0), 34'd4);
`endif
    drained("t7_drain");

    // random frames
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      case (r)
        0: send_frame(8'hE0, 0, 0);
        1: send_frame(8'hF0, 0, 0);
        2, 3: begin
          case ($urandom_range(0, 3))
            0: b = 8'h12; 1: b = 8'h59; 2: b = 8'h14; default: b = 8'h11;
          endcase
          send_frame(b, 0, 0);
        end
        4: send_frame(b, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0);
        default: send_frame(b, 0, 0);
      endcase
      drained("rand_drain");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end
endmodule
